i2s_rcvr: RTL and testbench



---
 rtl/i2s_rcvr_pkg.sv | 20 ++
 rtl/i2s_rcvr_sync.sv | 42 ++++
 rtl/i2s_rcvr.sv | 120 ++++++++++++
 tb/tb_i2s_rcvr.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rcvr_pkg.sv
// Shared types and constants for the I2S receiver.
package i2s_rcvr_pkg;

    // Framing state: waiting for the first ws edge, or collecting a left/right word
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    localparam int WORD_W_DEF = 16;

    // Bit counter must reach WORD_W+1 so over-long words are still recognised
    function automatic int cnt_width(input int word_w);
        return $clog2(word_w + 2);
    endfunction

    localparam int CNT_W = cnt_width(WORD_W_DEF);

endpackage

// File: rtl/i2s_rcvr_sync.sv
// Input synchronizers for the I2S pins plus a registered sck rising-edge detector.
// sck, ws and sd share the same chain depth so ws_s/sd_s line up with sck_rise.
module i2s_rcvr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic ws,
    input  logic sd,
    output logic sck_rise,
    output logic ws_s,
    output logic sd_s
);

    logic [SYNC_STAGES-1:0] sck_ff;
    logic [SYNC_STAGES-1:0] ws_ff;
    logic [SYNC_STAGES-1:0] sd_ff;
    logic                   sck_prev;

    // Shift the pins through the synchronizer chains and flag a 0->1 on synchronized sck
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_ff   <= '0;
            ws_ff    <= '0;
            sd_ff    <= '0;
            sck_prev <= 1'b0;
            sck_rise <= 1'b0;
            ws_s     <= 1'b0;
            sd_s     <= 1'b0;
        end else begin
            sck_ff   <= {sck_ff[SYNC_STAGES-2:0], sck};
            ws_ff    <= {ws_ff[SYNC_STAGES-2:0], ws};
            sd_ff    <= {sd_ff[SYNC_STAGES-2:0], sd};
            sck_prev <= sck_ff[SYNC_STAGES-1];
            sck_rise <= sck_ff[SYNC_STAGES-1] & ~sck_prev;
            ws_s     <= ws_ff[SYNC_STAGES-1];
            sd_s     <= sd_ff[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/i2s_rcvr.sv
// I2S receiver: deserializes MSB-first left/right words and emits one stereo
// frame per ws period with a single-cycle valid strobe.
module i2s_rcvr
    import i2s_rcvr_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sd,
    output logic [2*WORD_W-1:0]   parallel_data,
    output logic                  data_valid,
    output logic                  len_err,
    output logic                  ws_flag
);

    localparam int CNT_W_L = cnt_width(WORD_W);
    localparam int IDX_W   = $clog2(WORD_W);
    localparam logic [CNT_W_L-1:0] CNT_FULL = CNT_W_L'(WORD_W);
    localparam logic [CNT_W_L-1:0] CNT_LAST = CNT_W_L'(WORD_W - 1);
    localparam logic [CNT_W_L-1:0] CNT_ONE  = CNT_W_L'(1);

    logic              sck_rise;
    logic              ws_s;
    logic              sd_s;
    state_t            state;
    logic              ws_prev;
    logic [CNT_W_L-1:0] bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] left_hold;
    logic              left_ok;
    logic [WORD_W-1:0] word_next;
    logic [IDX_W-1:0]  bit_pos;
    logic              ws_change;
    logic              len_bad;

    i2s_rcvr_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .ws       (ws),
        .sd       (sd),
        .sck_rise (sck_rise),
        .ws_s     (ws_s),
        .sd_s     (sd_s)
    );

    // Word with the current bit merged in; bit_cnt holds bits taken before this one,
    // so a close with bit_cnt == WORD_W-1 is exactly WORD_W bits long
    always_comb begin
        word_next = shreg;
        bit_pos   = IDX_W'(WORD_W - 1) - IDX_W'(bit_cnt);
        if (bit_cnt < CNT_FULL) begin
            word_next[bit_pos] = sd_s;
        end
        ws_change = sck_rise && (ws_s != ws_prev);
        len_bad   = (bit_cnt != CNT_LAST);
    end

    // Framing FSM, bit counter, shifter and output registers, all advanced on sck_rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SYNC;
            ws_prev       <= 1'b0;
            bit_cnt       <= '0;
            shreg         <= '0;
            left_hold     <= '0;
            left_ok       <= 1'b0;
            parallel_data <= '0;
            data_valid    <= 1'b0;
            len_err       <= 1'b0;
            ws_flag       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            len_err    <= 1'b0;
            if (sck_rise) begin
                ws_prev <= ws_s;
                ws_flag <= ws_s;
                if (ws_change) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    case (state)
                        SYNC: begin
                            state <= ws_s ? RIGHT : LEFT;
                        end
                        LEFT: begin
                            left_hold <= word_next;
                            left_ok   <= 1'b1;
                            len_err   <= len_bad;
                            state     <= RIGHT;
                        end
                        RIGHT: begin
                            len_err <= len_bad;
                            if (left_ok) begin
                                parallel_data <= {left_hold, word_next};
                                data_valid    <= 1'b1;
                                left_ok       <= 1'b0;
                            end
                            state <= LEFT;
                        end
                        default: begin
                            state <= SYNC;
                        end
                    endcase
                end else begin
                    shreg <= word_next;
                    if (bit_cnt != CNT_FULL) begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rcvr.sv
// Directed bench for i2s_rcvr: a behavioural I2S transmitter drives the pins and
// expected frames go into a scoreboard queue that a monitor drains on data_valid.
module tb_i2s_rcvr;

    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        ws  = 1'b0;
    logic        sd  = 1'b0;
    logic [31:0] parallel_data;
    logic        data_valid;
    logic        len_err;
    logic        ws_flag;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          dv_count = 0;
    int          le_count = 0;
    logic        dv_prev  = 1'b0;
    logic [31:0] expq[$];
    logic [31:0] exp_v;
    int          dv_base;
    int          le_base;

    i2s_rcvr dut (
        .clk           (clk),
        .rst           (rst),
        .sck           (sck),
        .ws            (ws),
        .sd            (sd),
        .parallel_data (parallel_data),
        .data_valid    (data_valid),
        .len_err       (len_err),
        .ws_flag       (ws_flag)
    );

    // System clock, 4x the bench sck rate
    always #5 clk = ~clk;

    // Scoreboard monitor: every valid pops one expected frame; valid must never repeat back to back
    always @(negedge clk) begin
        if (!rst) begin
            if (len_err) le_count++;
            if (data_valid) begin
                dv_count++;
                n_tests++;
                assert (dv_prev === 1'b0) else begin
                    n_fail++;
                    $error("[TB] FAIL back_to_back_valid got=%b exp=0", dv_prev);
                end
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $error("[TB] FAIL unexpected_valid got=%h exp=none", parallel_data);
                end else begin
                    exp_v = expq.pop_front();
                    assert (parallel_data === exp_v) else begin
                        n_fail++;
                        $error("[TB] FAIL frame got=%h exp=%h", parallel_data, exp_v);
                    end
                end
            end
        end
        dv_prev = data_valid;
    end

    // Global time limit so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One sck period: data and ws change with sck low, receiver samples on the rise
    task automatic applyStimulus(input logic w, input logic d);
        ws = w;
        sd = d;
        #HALF;
        sck = 1'b1;
        #HALF;
        sck = 1'b0;
    endtask

    // MSB-first word; its LSB travels with ws already switched to the next channel
    task automatic send_word(input logic ch, input logic [31:0] data, input int n, input logic next_ch);
        for (int i = n - 1; i >= 1; i--) applyStimulus(ch, data[i]);
        applyStimulus(next_ch, data[0]);
    endtask

    // Independent model of the received word: keep the first 16 bits, zero-fill short words
    function automatic logic [15:0] model_word(input logic [31:0] d, input int n);
        if (n >= 16) return 16'(d >> (n - 16));
        else         return 16'(d << (16 - n));
    endfunction

    task automatic send_frame(input logic [31:0] l, input int ln, input logic [31:0] r, input int rn);
        expq.push_back({model_word(l, ln), model_word(r, rn)});
        send_word(1'b0, l, ln, 1'b1);
        send_word(1'b1, r, rn, 1'b0);
    endtask

    // From SYNC with ws low: a ws rise enters RIGHT, then a dropped right word leads into LEFT
    task automatic prelude();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        send_word(1'b1, 32'h0000_5A5A, 16, 1'b0);
    endtask

    // Wait (bounded) for the scoreboard to empty, then confirm it did
    task automatic drain();
        for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        checkOutput("queue_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #($urandom_range(1, 3));
        #40;
        checkOutput("rst_parallel_data", parallel_data, 32'h0);
        checkOutput("rst_data_valid", {31'b0, data_valid}, 32'h0);
        checkOutput("rst_len_err", {31'b0, len_err}, 32'h0);
        checkOutput("rst_ws_flag", {31'b0, ws_flag}, 32'h0);
        rst = 1'b0;
        #40;

        // Loopback with a constant frame
        prelude();
        dv_base = dv_count;
        le_base = le_count;
        for (int i = 0; i < 4; i++) send_frame(32'hA5C3, 16, 32'h3C5A, 16);
        drain();
        checkOutput("loop_valid_count", 32'(dv_count - dv_base), 32'd4);
        checkOutput("loop_len_err", 32'(le_count - le_base), 32'd0);
        checkOutput("loop_ws_flag", {31'b0, ws_flag}, 32'h0);

        // Short left word
        le_base = le_count;
        send_frame(32'hFFF, 12, 32'h1234, 16);
        drain();
        checkOutput("short_len_err", 32'(le_count - le_base), 32'd1);

        // Long right word
        le_base = le_count;
        send_frame(32'h0001, 16, 32'hABCDE, 20);
        drain();
        checkOutput("long_len_err", 32'(le_count - le_base), 32'd1);

        // Reset while the 8th left bit is captured
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1);
        ws = 1'b0;
        sd = 1'b1;
        #HALF;
        sck = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_parallel_data", parallel_data, 32'h0);
        checkOutput("midrst_data_valid", {31'b0, data_valid}, 32'h0);
        checkOutput("midrst_len_err", {31'b0, len_err}, 32'h0);
        checkOutput("midrst_ws_flag", {31'b0, ws_flag}, 32'h0);
        #(HALF - 1);
        sck = 1'b0;
        #40;
        rst = 1'b0;
        #40;
        dv_base = dv_count;
        le_base = le_count;
        prelude();
        repeat (10) @(negedge clk);
        #($urandom_range(1, 3));
        checkOutput("midrst_no_early_valid", 32'(dv_count - dv_base), 32'd0);
        send_frame(32'h1357, 16, 32'h2468, 16);
        drain();
        checkOutput("midrst_valid_count", 32'(dv_count - dv_base), 32'd1);
        checkOutput("midrst_len_err", 32'(le_count - le_base), 32'd0);

        // Release reset while ws is high in the middle of a right word
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
        rst = 1'b0;
        #40;
        dv_base = dv_count;
        le_base = le_count;
        applyStimulus(1'b1, 1'b0);
        #60;
        checkOutput("right_start_ws_flag", {31'b0, ws_flag}, 32'h1);
        send_word(1'b1, 32'h0000_C3C3, 16, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        checkOutput("right_start_dropped", 32'(dv_count - dv_base), 32'd0);
        send_frame(32'h8000, 16, 32'h0001, 16);
        drain();
        checkOutput("right_start_valid_count", 32'(dv_count - dv_base), 32'd1);
        checkOutput("right_start_len_err", 32'(le_count - le_base), 32'd0);

        // Random frames at the minimum clock ratio
        dv_base = dv_count;
        le_base = le_count;
        for (int i = 0; i < 100; i++) begin
            send_frame(32'($urandom_range(0, 65535)), 16, 32'($urandom_range(0, 65535)), 16);
        end
        drain();
        checkOutput("random_valid_count", 32'(dv_count - dv_base), 32'd100);
        checkOutput("random_len_err", 32'(le_count - le_base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
